vec_issue_ctrl: RTL and testbench

- Sequencer between the scalar core and the vector front end.
- Accepts one vector instruction at a time over a valid/ready handshake and holds it for the duration of its execution.
- Drives the vec_decode configuration selects (vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel) and the CSR write strobe for vsetvl-family instructions.
- Sequences arithmetic instructions as ceil(vl/LANES) execution beats, holds a load request until the LSU finishes, then pulses completion back to the scalar core.

---
 rtl/vec_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_vec_issue_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl: sequencer between the scalar core and the vector front end.
// It accepts one vector instruction at a time and holds it in inst_q while
// the instruction runs. CONF instructions write vl/vtype in one cycle.
// ARITH instructions issue ceil(vl/LANES) execution beats. LOAD instructions
// hold lsu_req until the LSU reports done. Each supported instruction ends
// with a single-cycle inst_done pulse.
//
// Handshakes: an instruction transfers on a cycle where inst_valid and
// inst_ready are both high. inst_ready depends only on the state, so
// inst_valid may be held high while waiting. An execution beat is taken on
// any cycle where exe_valid=1 and exe_stall=0. While the beat is stalled,
// exe_beat_idx and exe_last keep their values.
module vec_issue_ctrl #(
  parameter int XLEN   = 32,
  parameter int LANES  = 4,
  parameter int MAX_VL = 512
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              inst_valid,
  output logic                              inst_ready,
  input  logic [XLEN-1:0]                   vec_inst,
  input  logic [XLEN-1:0]                   vl_current,
  output logic                              vl_sel,
  output logic                              vtype_sel,
  output logic                              lumop_sel,
  output logic                              rs1rd_de,
  output logic                              rs1_sel,
  output logic                              csr_wr_en,
  output logic                              exe_valid,
  output logic [$clog2(MAX_VL/LANES)-1:0]   exe_beat_idx,
  output logic                              exe_last,
  input  logic                              exe_stall,
  output logic                              lsu_req,
  input  logic                              lsu_done,
  output logic                              inst_done,
  output logic                              illegal,
  output logic                              busy
);

  localparam int BW = $clog2(MAX_VL / LANES);  // beat index width
  localparam int VW = $clog2(MAX_VL + 1);      // vl register width
  localparam int LW = $clog2(LANES);           // shift for the lane divide
  localparam int NW = BW + 1;                  // beat count width (holds MAX_VL/LANES)

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CONF  = 3'd1;
  localparam logic [2:0] S_ARITH = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state;
  logic [XLEN-1:0] inst_q;
  logic [VW-1:0]   vl_q;
  logic [BW-1:0]   count;
  logic            illegal_q;

  // Decode of the word presented for acceptance.
  logic [6:0] op_in;
  logic [2:0] f3_in;
  logic       in_conf;
  logic       in_arith;
  logic       in_load;

  assign op_in    = vec_inst[6:0];
  assign f3_in    = vec_inst[14:12];
  assign in_conf  = (op_in == 7'h57) && (f3_in == 3'b111);
  assign in_arith = (op_in == 7'h57) &&
                    ((f3_in == 3'b000) || (f3_in == 3'b011) || (f3_in == 3'b100));
  assign in_load  = (op_in == 7'h07);

  // vl is clamped at acceptance and is not read again later.
  logic [VW-1:0] vl_clamp;
  assign vl_clamp = (vl_current > XLEN'(MAX_VL)) ? VW'(MAX_VL) : vl_current[VW-1:0];

  // Beat count: ceil(vl_q / LANES). It is computed with one extra bit so
  // that rounding up MAX_VL cannot overflow.
  logic [VW:0]   vl_round;
  logic [VW:0]   nbeats_w;
  logic [NW-1:0] nbeats;
  logic          last_beat;

  assign vl_round  = {1'b0, vl_q} + (VW+1)'(LANES - 1);
  assign nbeats_w  = vl_round >> LW;
  assign nbeats    = nbeats_w[NW-1:0];
  assign last_beat = ({1'b0, count} == (nbeats - NW'(1)));

  // Only the fields that steer the CONF selects are read back from inst_q.
  // The remaining bits are held so that the full word stays visible.
  logic unused_bits;
  assign unused_bits = ^{inst_q[29:20], inst_q[14:0], nbeats_w[VW:NW]};

  // Sequencer state, the instruction/vl capture and the beat counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      inst_q    <= '0;
      vl_q      <= '0;
      count     <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (inst_valid) begin
            inst_q <= vec_inst;
            vl_q   <= vl_clamp;
            count  <= '0;
            if (in_conf)       state     <= S_CONF;
            else if (in_arith) state     <= S_ARITH;
            else if (in_load)  state     <= S_LOAD;
            else               illegal_q <= 1'b1;
          end
        end
        S_CONF:  state <= S_DONE;
        S_ARITH: begin
          if (vl_q == '0) begin
            state <= S_DONE;
          end else if (!exe_stall) begin
            if (last_beat) state <= S_DONE;
            else           count <= count + BW'(1);
          end
        end
        S_LOAD:  if (lsu_done) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // vec_decode selects for CONF and LOAD instructions.
  // VSETIVLI takes its AVL from uimm, so rs1=x0 means VLMAX only for the
  // register forms.
  logic conf_ivli;
  assign conf_ivli = (inst_q[31:30] == 2'b11);

  // Drive the decode selects from the held instruction. They are 0 in every
  // other state.
  always_comb begin
    vl_sel    = 1'b0;
    vtype_sel = 1'b0;
    lumop_sel = 1'b0;
    rs1rd_de  = 1'b0;
    rs1_sel   = 1'b0;
    if (state == S_CONF) begin
      vl_sel    = conf_ivli;
      vtype_sel = ~inst_q[31] | conf_ivli;
      rs1_sel   = conf_ivli;
      rs1rd_de  = conf_ivli | (inst_q[19:15] != 5'd0);
    end else if (state == S_LOAD) begin
      lumop_sel = 1'b1;
      rs1rd_de  = 1'b1;
    end
  end

  assign inst_ready   = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign csr_wr_en    = (state == S_CONF);
  assign exe_valid    = (state == S_ARITH) && (vl_q != '0);
  assign exe_beat_idx = exe_valid ? count : '0;
  assign exe_last     = exe_valid && last_beat;
  assign lsu_req      = (state == S_LOAD);
  assign inst_done    = (state == S_DONE);
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Testbench for vec_issue_ctrl. It runs three groups of tests, and each
// expected cycle is checked against a packed snapshot of the outputs:
//  - a hand-built table of instructions with their expected outputs
//  - hand-written sequences for the multi-cycle corner cases
//  - random instructions whose expected results come from a reference model
module tb_vec_issue_ctrl;

  localparam int LANES  = 4;
  localparam int MAX_VL = 512;

  localparam int K_CONF  = 0;
  localparam int K_ARITH = 1;
  localparam int K_LOAD  = 2;
  localparam int K_ILL   = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] vec_inst;
  logic [31:0] vl_current;
  logic        vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel, csr_wr_en;
  logic        exe_valid;
  logic [6:0]  exe_beat_idx;
  logic        exe_last;
  logic        exe_stall;
  logic        lsu_req;
  logic        lsu_done;
  logic        inst_done;
  logic        illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  vec_issue_ctrl dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .vec_inst(vec_inst), .vl_current(vl_current), .vl_sel(vl_sel),
    .vtype_sel(vtype_sel), .lumop_sel(lumop_sel), .rs1rd_de(rs1rd_de),
    .rs1_sel(rs1_sel), .csr_wr_en(csr_wr_en), .exe_valid(exe_valid),
    .exe_beat_idx(exe_beat_idx), .exe_last(exe_last), .exe_stall(exe_stall),
    .lsu_req(lsu_req), .lsu_done(lsu_done), .inst_done(inst_done),
    .illegal(illegal), .busy(busy)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Snapshot layout: {ready, busy, vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel,
  //                   csr, exe_valid, exe_last, lsu_req, done, illegal, idx[6:0]}
  function automatic logic [19:0] mk(input logic rdy, input logic bsy, input logic [4:0] s,
                                     input logic csr, input logic ev, input logic lst,
                                     input logic lsu, input logic dn, input logic ill,
                                     input logic [6:0] idx);
    return {rdy, bsy, s, csr, ev, lst, lsu, dn, ill, idx};
  endfunction

  function automatic logic [19:0] dut_vec();
    return {inst_ready, busy, vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel,
            csr_wr_en, exe_valid, exe_last, lsu_req, inst_done, illegal, exe_beat_idx};
  endfunction

  function automatic logic [19:0] idle_vec();
    return mk(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
  endfunction

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model. It decides the instruction class, the decode selects
  // {vl_sel, vtype_sel, lumop_sel, rs1rd_de, rs1_sel} and the beat count.
  task automatic ref_expect(input logic [31:0] w, input logic [31:0] vl,
                            output int kind, output logic [4:0] sels, output int nb);
    logic ivli;
    longint eff;
    sels = 5'b0;
    nb   = 0;
    ivli = (w[31:30] == 2'b11);
    if (w[6:0] == 7'h57 && w[14:12] == 3'd7) begin
      kind = K_CONF;
      sels = {ivli, (!w[31]) || ivli, 1'b0, !((w[19:15] == 5'd0) && !ivli), ivli};
    end else if (w[6:0] == 7'h57 && (w[14:12] == 3'd0 || w[14:12] == 3'd3 || w[14:12] == 3'd4)) begin
      kind = K_ARITH;
      eff  = (vl > MAX_VL) ? MAX_VL : vl;
      nb   = int'((eff + LANES - 1) / LANES);
    end else if (w[6:0] == 7'h07) begin
      kind = K_LOAD;
      sels = 5'b00110;
    end else begin
      kind = K_ILL;
    end
  endtask

  // Driver and checker for one instruction. It checks the outputs on every
  // cycle from the accepting cycle up to the cycle after inst_done.
  // lat returns the number of cycles from the accepting edge to inst_done.
  task automatic run_inst(input logic [31:0] word, input logic [31:0] vl,
                          input int stall_idx, input int stall_cnt, input int stall_pct,
                          input int lsu_delay, input int kind, input logic [4:0] sels,
                          input int nb, output int lat);
    int   cyc;
    int   stalled;
    logic st;
    lat = -1;
    chk("accept idle", dut_vec(), idle_vec());
    inst_valid = 1'b1;
    vec_inst   = word;
    vl_current = vl;
    step();
    inst_valid = 1'b0;
    vec_inst   = $urandom;
    vl_current = $urandom;
    cyc        = 1;
    case (kind)
      K_CONF: begin
        chk("conf csr", dut_vec(), mk(1'b0, 1'b1, sels, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0));
        exe_stall = 1'($urandom);
        lsu_done  = 1'($urandom);
        step();
        cyc++;
      end
      K_ARITH: begin
        exp_q.delete();
        for (int i = 0; i < nb; i++) exp_q.push_back(7'(i));
        if (nb == 0) begin
          chk("arith empty", dut_vec(), mk(1'b0, 1'b1, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0));
          step();
          cyc++;
        end else begin
          stalled = 0;
          while (exp_q.size() > 0 && cyc < 3000) begin
            chk("arith beat", dut_vec(),
                mk(1'b0, 1'b1, 5'b0, 1'b0, 1'b1, exp_q.size() == 1, 1'b0, 1'b0, 1'b0, exp_q[0]));
            if (int'(exp_q[0]) == stall_idx && stalled < stall_cnt) begin
              st = 1'b1;
              stalled++;
            end else begin
              st = ($urandom_range(0, 99) < stall_pct);
            end
            exe_stall = st;
            lsu_done  = 1'($urandom);
            step();
            cyc++;
            if (!st) void'(exp_q.pop_front());
          end
          if (exp_q.size() > 0) chk_int("arith cycle budget", exp_q.size(), 0);
        end
        exe_stall = 1'b0;
        lsu_done  = 1'b0;
      end
      K_LOAD: begin
        for (int k = 1; k <= lsu_delay; k++) begin
          chk("load req", dut_vec(), mk(1'b0, 1'b1, sels, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0));
          lsu_done  = (k == lsu_delay);
          exe_stall = 1'($urandom);
          step();
          cyc++;
        end
        lsu_done  = 1'b0;
        exe_stall = 1'b0;
      end
      default: begin
        chk("illegal pulse", dut_vec(), mk(1'b1, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0));
        step();
      end
    endcase
    if (kind != K_ILL) begin
      chk("done pulse", dut_vec(), mk(1'b0, 1'b1, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0));
      lat = cyc;
      step();
    end
    chk("ready again", dut_vec(), idle_vec());
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] vl;
    int          lsu_delay;
    int          kind;
    logic [4:0]  sels;
    int          nb;
    int          lat;
  } vec_t;

  localparam logic [31:0] VSETVLI    = 32'h0C0572D7;
  localparam logic [31:0] VSETVLI_X0 = 32'h0C0072D7;
  localparam logic [31:0] VSETIVLI   = 32'hCC02F2D7;
  localparam logic [31:0] VSETVL_X0  = 32'h80B072D7;
  localparam logic [31:0] VADD_VV    = 32'h022081D7;
  localparam logic [31:0] VADD_VI    = 32'h022031D7;
  localparam logic [31:0] VADD_VX    = 32'h022041D7;
  localparam logic [31:0] OPMVV      = 32'h0220A1D7;
  localparam logic [31:0] VLE32      = 32'h02056207;
  localparam logic [31:0] ADD_X      = 32'h002081B3;

  vec_t tbl[16];

  initial begin
    int          lat;
    int          kind;
    int          nb;
    logic [4:0]  sels;
    logic [31:0] w;
    logic [31:0] vl;

    reset      = 1'b0;
    inst_valid = 1'b1;
    vec_inst   = VSETVLI;
    vl_current = 32'd3;
    exe_stall  = 1'b0;
    lsu_done   = 1'b0;
    repeat (3) step();
    chk("reset state", dut_vec(), idle_vec());
    inst_valid = 1'b0;
    reset      = 1'b1;
    step();
    chk("after reset", dut_vec(), idle_vec());

    // Table of instructions with expected outputs.
    tbl[0]  = '{VSETVLI,    32'd7,    0, K_CONF,  5'b01010, 0,   2};
    tbl[1]  = '{VSETIVLI,   32'd7,    0, K_CONF,  5'b11011, 0,   2};
    tbl[2]  = '{VSETVL_X0,  32'd7,    0, K_CONF,  5'b00000, 0,   2};
    tbl[3]  = '{VSETVLI_X0, 32'd7,    0, K_CONF,  5'b01000, 0,   2};
    tbl[4]  = '{VADD_VV,    32'd10,   0, K_ARITH, 5'b00000, 3,   4};
    tbl[5]  = '{VADD_VV,    32'd0,    0, K_ARITH, 5'b00000, 0,   2};
    tbl[6]  = '{VADD_VV,    32'd1000, 0, K_ARITH, 5'b00000, 128, 129};
    tbl[7]  = '{VADD_VV,    32'd512,  0, K_ARITH, 5'b00000, 128, 129};
    tbl[8]  = '{VADD_VV,    32'd4,    0, K_ARITH, 5'b00000, 1,   2};
    tbl[9]  = '{VADD_VI,    32'd5,    0, K_ARITH, 5'b00000, 2,   3};
    tbl[10] = '{VADD_VX,    32'd3,    0, K_ARITH, 5'b00000, 1,   2};
    tbl[11] = '{VLE32,      32'd9,    7, K_LOAD,  5'b00110, 0,   8};
    tbl[12] = '{VLE32,      32'd9,    1, K_LOAD,  5'b00110, 0,   2};
    tbl[13] = '{OPMVV,      32'd9,    0, K_ILL,   5'b00000, 0,   -1};
    tbl[14] = '{ADD_X,      32'd9,    0, K_ILL,   5'b00000, 0,   -1};
    tbl[15] = '{VADD_VV,    32'd513,  0, K_ARITH, 5'b00000, 128, 129};

    for (int i = 0; i < 16; i++) begin
      run_inst(tbl[i].word, tbl[i].vl, -1, 0, 0, tbl[i].lsu_delay,
               tbl[i].kind, tbl[i].sels, tbl[i].nb, lat);
      if (tbl[i].kind != K_ILL) chk_int($sformatf("latency row %0d", i), lat, tbl[i].lat);
      step();
    end

    // vadd.vv with 3 beats. Beat 1 is stalled for 2 cycles, so idx 1 is held
    // for 3 cycles and inst_done arrives 6 cycles after accept.
    run_inst(VADD_VV, 32'd10, 1, 2, 0, 0, K_ARITH, 5'b0, 3, lat);
    chk_int("stall latency", lat, 6);

    // Reset while beat 2 of a 10-beat ARITH instruction is on the outputs.
    chk("abort accept idle", dut_vec(), idle_vec());
    inst_valid = 1'b1;
    vec_inst   = VADD_VV;
    vl_current = 32'd40;
    step();
    inst_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("pre-abort beat", dut_vec(), mk(1'b0, 1'b1, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'(i)));
      step();
    end
    chk("abort beat 2", dut_vec(), mk(1'b0, 1'b1, 5'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd2));
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("abort reset state", dut_vec(), idle_vec());
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no done after abort", dut_vec(), idle_vec());
    end

    // Random instructions checked against the reference model.
    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      case ($urandom_range(0, 4))
        0: begin
          w[6:0]   = 7'h57;
          w[14:12] = 3'd7;
          if ($urandom_range(0, 1) == 1) w[19:15] = 5'd0;
        end
        1: begin
          w[6:0] = 7'h57;
          case ($urandom_range(0, 2))
            0:       w[14:12] = 3'd0;
            1:       w[14:12] = 3'd3;
            default: w[14:12] = 3'd4;
          endcase
        end
        2: w[6:0] = 7'h07;
        3: begin
          w[6:0] = 7'h57;
          case ($urandom_range(0, 3))
            0:       w[14:12] = 3'd1;
            1:       w[14:12] = 3'd2;
            2:       w[14:12] = 3'd5;
            default: w[14:12] = 3'd6;
          endcase
        end
        default: ;
      endcase
      case ($urandom_range(0, 2))
        0:       vl = $urandom_range(0, 40);
        1:       vl = $urandom_range(0, 600);
        default: vl = $urandom;
      endcase
      ref_expect(w, vl, kind, sels, nb);
      run_inst(w, vl, -1, 0, $urandom_range(0, 50), $urandom_range(1, 10), kind, sels, nb, lat);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
